vector_irq_ctrl: RTL

- Vectored interrupt controller; the responder end of the CPU interrupt-acknowledge handshake (virq / istb / ivec / iack) of the processor modules.
- Collects request lines from up to N peripherals and resolves fixed priority.
- Raises the CPU virq line. On the CPU istb strobe, returns the winning device's 16-bit vector with a registered iack and pulses a per-device acknowledge so the device withdraws its request.

---
 rtl/vector_irq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vector_irq_ctrl.sv
// Vectored interrupt controller: fixed-priority responder for virq/istb/ivec/iack.
// Optional macro VIC_EDGE_LATCH_EN: per-channel rising-edge pending latches.
module vector_irq_ctrl #(
    parameter int          N        = 4,
    parameter logic [15:0] SPUR_VEC = 16'o000004
) (
    input  logic            clk_p,
    input  logic            rst_n,
    input  logic            init,
    input  logic [N-1:0]    irq_i,
    input  logic [16*N-1:0] ivec_i,
    output logic [N-1:0]    irq_ack_o,
    output logic            virq_o,
    input  logic            istb_i,
    output logic            iack_o,
    output logic [15:0]     ivec_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          virq_q, virq_d;
    logic          iack_q, iack_d;
    logic [15:0]   ivec_q, ivec_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  active;
    logic [N-1:0]  grant;
    logic [IW-1:0] win_idx;
    logic          any_act;

`ifdef VIC_EDGE_LATCH_EN
    logic [N-1:0] prev_q;
    logic [N-1:0] pend_q, pend_d;

    // A rise in the same cycle as the ack pulse wins, so no pulse is lost.
    assign pend_d = (pend_q & ~ack_q) | (irq_i & ~prev_q);
    assign active = pend_q;

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
        end else if (init) begin
            prev_q <= irq_i;
            pend_q <= '0;
        end else begin
            prev_q <= irq_i;
            pend_q <= pend_d;
        end
    end
`else
    assign active = irq_i;
`endif

    always_comb begin
        win_idx = '0;
        grant   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (active[k]) begin
                win_idx  = IW'(k);
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end

    assign any_act = |active;

    always_comb begin
        state_d = state_q;
        virq_d  = 1'b0;
        iack_d  = iack_q;
        ivec_d  = ivec_q;
        ack_d   = '0;
        if (init) begin
            state_d = S_IDLE;
            iack_d  = 1'b0;
            ivec_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    virq_d = any_act;
                    if (istb_i) begin
                        ivec_d  = any_act ? ivec_i[{win_idx, 4'b0000} +: 16]
                                          : SPUR_VEC;
                        iack_d  = 1'b1;
                        ack_d   = grant;
                        virq_d  = 1'b0;
                        state_d = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!istb_i) begin
                        iack_d  = 1'b0;
                        ivec_d  = '0;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    state_d = S_IDLE;
                end
                default: begin
                    iack_d  = 1'b0;
                    ivec_d  = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            virq_q  <= 1'b0;
            iack_q  <= 1'b0;
            ivec_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            virq_q  <= virq_d;
            iack_q  <= iack_d;
            ivec_q  <= ivec_d;
            ack_q   <= ack_d;
        end
    end

    assign virq_o    = virq_q;
    assign iack_o    = iack_q;
    assign ivec_o    = ivec_q;
    assign irq_ack_o = ack_q;

endmodule
